// File: rtl/rom_4001.sv
// 256x8 program ROM plus 4-bit I/O port on the nibble bus, with a wishbone backdoor for loading.
// Optional: define ROM_IO_SYNC_EN to pass io_in through a two-flop synchronizer before RDR.
module rom_4001 #(
  parameter logic [3:0] CHIP_ID = 4'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  data_i,
  output logic [3:0]  data_o,
  output logic        data_en,
  input  logic        sync,
  input  logic        cmd_n,
  input  logic [3:0]  io_in,
  output logic [3:0]  io_out,
  input  logic [31:0] wb_data_i,
  input  logic [31:0] wb_addr_i,
  input  logic        wb_cyc_i,
  input  logic        wb_strobe_i,
  input  logic        wb_we_i,
  output logic [31:0] wb_data_o,
  output logic        wb_ack_o
);

  localparam logic [3:0] INST_WRR = 4'h2;
  localparam logic [3:0] INST_RDR = 4'hA;

  logic [2:0] cycle;
  logic [7:0] addr;
  logic       fetch_sel;
  logic       io_sel;
  logic [3:0] inst;
  logic       inst_active;
  logic [7:0] rom [0:255];
  logic [3:0] io_rd;
  logic       cmd;
  logic       wb_go;
  logic       wb_unused;

  assign cmd       = !cmd_n;
  assign wb_go     = (cycle == 3'd7) && !wb_ack_o && wb_cyc_i && wb_strobe_i;
  assign wb_unused = ^{wb_addr_i[31:9], wb_data_i[31:8]};

`ifdef ROM_IO_SYNC_EN
  logic [3:0] io_s1, io_s2;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      io_s1 <= 4'h0;
      io_s2 <= 4'h0;
    end else begin
      io_s1 <= io_in;
      io_s2 <= io_s1;
    end
  end

  assign io_rd = io_s2;
`else
  assign io_rd = io_in;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cycle       <= 3'd0;
      addr        <= 8'h00;
      fetch_sel   <= 1'b0;
      io_sel      <= 1'b0;
      inst        <= 4'h0;
      inst_active <= 1'b0;
      io_out      <= 4'h0;
      wb_ack_o    <= 1'b0;
      wb_data_o   <= 32'h0;
    end else begin
      cycle    <= sync ? 3'd0 : cycle + 3'd1;
      wb_ack_o <= wb_go;
      case (cycle)
        3'd0: addr[3:0] <= data_i;
        3'd1: addr[7:4] <= data_i;
        3'd2: fetch_sel <= (data_i == CHIP_ID);
        3'd4: begin
          fetch_sel <= 1'b0;
          if (cmd && io_sel) begin
            inst        <= data_i;
            inst_active <= 1'b1;
          end
        end
        3'd6: begin
          if (cmd) io_sel <= (data_i == CHIP_ID);
          if (inst_active && inst == INST_WRR) io_out <= data_i;
        end
        3'd7: inst_active <= 1'b0;
        default: ;
      endcase
      // backdoor only runs in X3, so it never collides with a WRR in X2
      if (wb_go) begin
        if (wb_addr_i[8]) begin
          wb_data_o <= {28'h0, io_out};
          if (wb_we_i) io_out <= wb_data_i[3:0];
        end else begin
          wb_data_o <= {24'h0, rom[wb_addr_i[7:0]]};
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (wb_go && !wb_addr_i[8] && wb_we_i) rom[wb_addr_i[7:0]] <= wb_data_i[7:0];
  end

  always_comb begin
    data_en = 1'b0;
    data_o  = 4'h0;
    if (fetch_sel && cycle == 3'd3) begin
      data_en = 1'b1;
      data_o  = rom[addr][7:4];
    end else if (fetch_sel && cycle == 3'd4) begin
      data_en = 1'b1;
      data_o  = rom[addr][3:0];
    end else if (inst_active && cycle == 3'd6 && inst == INST_RDR) begin
      data_en = 1'b1;
      data_o  = io_rd;
    end
  end

endmodule

// File: tb/tb_rom_4001.sv
// Randomized bench for rom_4001: drives whole 8-cycle bus frames and checks against a frame-level model.
module tb_rom_4001;
  localparam logic [3:0] ID = 4'h0;

  logic        clock, reset;
  logic [3:0]  data_i, data_o, io_in, io_out;
  logic        data_en, sync, cmd_n;
  logic [31:0] wb_data_i, wb_addr_i, wb_data_o;
  logic        wb_cyc_i, wb_strobe_i, wb_we_i, wb_ack_o;

  rom_4001 #(.CHIP_ID(ID)) dut (
    .clock(clock), .reset(reset), .data_i(data_i), .data_o(data_o), .data_en(data_en),
    .sync(sync), .cmd_n(cmd_n), .io_in(io_in), .io_out(io_out),
    .wb_data_i(wb_data_i), .wb_addr_i(wb_addr_i), .wb_cyc_i(wb_cyc_i),
    .wb_strobe_i(wb_strobe_i), .wb_we_i(wb_we_i), .wb_data_o(wb_data_o), .wb_ack_o(wb_ack_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // reference state
  bit [7:0]  mrom [256];
  bit        mvalid [256];
  bit [3:0]  m_io_out;
  bit        m_io_sel;
  bit        m_ack;
  bit [31:0] m_wbdata;
  bit        m_wb_known;
  int        ack_count;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_io_out   = 4'h0;
    m_io_sel   = 1'b0;
    m_ack      = 1'b0;
    m_wbdata   = 32'h0;
    m_wb_known = 1'b1;
  endtask

  // One instruction cycle A1..X3. rst3 asserts reset asynchronously inside M1 and ends the frame.
  task automatic frame(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] a3,
                       input bit cm_m2, input logic [3:0] d_m2,
                       input bit cm_x2, input logic [3:0] d_x2,
                       input bit wb_req, input logic [8:0] wa, input bit we,
                       input logic [7:0] wd, input bit rst3);
    logic [7:0] fa;
    bit         fetch, act;
    logic [3:0] inst_m, exp_o;
    bit         exp_en;
    logic [3:0] io_c [8];
    fa = {a2, a1};
    fetch = (a3 == ID);
    act = 1'b0;
    inst_m = 4'h0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      data_i = 4'($urandom_range(0, 15));
      cmd_n  = 1'($urandom_range(0, 1));
      io_in  = 4'($urandom_range(0, 15));
      sync   = (c == 7);
      case (c)
        0: data_i = a1;
        1: data_i = a2;
        2: data_i = a3;
        4: begin data_i = d_m2; cmd_n = !cm_m2; end
        6: begin data_i = d_x2; cmd_n = !cm_x2; end
        default: ;
      endcase
      io_c[c]     = io_in;
      wb_strobe_i = wb_req;
      wb_cyc_i    = wb_req | 1'($urandom_range(0, 1));
      wb_we_i     = we;
      wb_addr_i   = ($urandom & 32'hFFFF_FE00) | {23'h0, wa};
      wb_data_i   = ($urandom & 32'hFFFF_FF00) | {24'h0, wd};
      #1;
      exp_en = 1'b0;
      exp_o  = 4'h0;
      if (fetch && c == 3) begin exp_en = 1'b1; exp_o = mrom[fa][7:4]; end
      if (fetch && c == 4) begin exp_en = 1'b1; exp_o = mrom[fa][3:0]; end
      if (c == 6 && act && inst_m == 4'hA) begin
        exp_en = 1'b1;
`ifdef ROM_IO_SYNC_EN
        exp_o = io_c[4];
`else
        exp_o = io_c[6];
`endif
      end
      check("data_en", data_en, exp_en);
      if (!(fetch && (c == 3 || c == 4) && !mvalid[fa])) check("data_o", data_o, exp_o);
      check("io_out", io_out, m_io_out);
      check("wb_ack", wb_ack_o, m_ack);
      if (wb_ack_o === 1'b1) ack_count++;
      if (m_wb_known) check("wb_data", wb_data_o, m_wbdata);
      if (rst3 && c == 3) begin
        #1 reset = 1'b1;
        #1;
        check("rst_data_en", data_en, 0);
        check("rst_data_o", data_o, 0);
        check("rst_io_out", io_out, 0);
        check("rst_wb_ack", wb_ack_o, 0);
        model_reset();
        wb_cyc_i = 1'b0;
        wb_strobe_i = 1'b0;
        @(posedge clock);
        #2 reset = 1'b0;
        return;
      end
      // state change at the edge ending cycle c
      m_ack = 1'b0;
      case (c)
        4: begin act = cm_m2 && m_io_sel; inst_m = d_m2; end
        6: begin
          if (act && inst_m == 4'h2) m_io_out = d_x2;
          if (cm_x2) m_io_sel = (d_x2 == ID);
        end
        7: if (wb_req) begin
          m_ack = 1'b1;
          if (wa[8]) begin
            m_wbdata = {28'h0, m_io_out};
            m_wb_known = 1'b1;
            if (we) m_io_out = wd[3:0];
          end else begin
            m_wbdata = {24'h0, mrom[wa[7:0]]};
            m_wb_known = mvalid[wa[7:0]];
            if (we) begin mrom[wa[7:0]] = wd; mvalid[wa[7:0]] = 1'b1; end
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic idle();
    frame(4'h0, 4'h0, ID + 4'h1, 0, 4'h0, 0, 4'h0, 0, 9'h0, 0, 8'h0, 0);
  endtask

  logic [3:0] ra3, rm2;
  int         sel;

  initial begin
    reset = 1'b0; data_i = 4'h0; sync = 1'b0; cmd_n = 1'b1; io_in = 4'h0;
    wb_data_i = 32'h0; wb_addr_i = 32'h0; wb_cyc_i = 1'b0; wb_strobe_i = 1'b0; wb_we_i = 1'b0;
    for (int i = 0; i < 256; i++) mvalid[i] = 1'b0;
    model_reset();
    ack_count = 0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_data_en", data_en, 0);
    check("reset_data_o", data_o, 0);
    check("reset_io_out", io_out, 0);
    check("reset_wb_ack", wb_ack_o, 0);
    check("reset_wb_data", wb_data_o, 0);
    @(posedge clock);
    #2 reset = 1'b0;

    // load 3C then fetch it, selected and unselected
    frame(4'h1, 4'h2, ID + 4'h1, 0, 4'h0, 0, 4'h0, 1, 9'h03C, 1, 8'hA7, 0);
    frame(4'hC, 4'h3, ID, 0, 4'h0, 0, 4'h0, 0, 9'h0, 0, 8'h0, 0);
    frame(4'hC, 4'h3, ID + 4'h1, 0, 4'h0, 0, 4'h0, 0, 9'h0, 0, 8'h0, 0);

    // SRC select, WRR 9, deselect, WRR ignored
    frame(4'h0, 4'h0, ID + 4'h1, 0, 4'h0, 1, ID, 0, 9'h0, 0, 8'h0, 0);
    frame(4'h0, 4'h0, ID + 4'h1, 1, 4'h2, 0, 4'h9, 0, 9'h0, 0, 8'h0, 0);
    frame(4'h0, 4'h0, ID + 4'h1, 0, 4'h0, 1, ID + 4'h1, 0, 9'h0, 0, 8'h0, 0);
    frame(4'h0, 4'h0, ID + 4'h1, 1, 4'h2, 0, 4'h3, 0, 9'h0, 0, 8'h0, 0);

    // RDR selected, then WRR 6 with a same-frame backdoor read of io_out, then held strobe
    frame(4'h0, 4'h0, ID + 4'h1, 0, 4'h0, 1, ID, 0, 9'h0, 0, 8'h0, 0);
    frame(4'h0, 4'h0, ID + 4'h1, 1, 4'hA, 0, 4'h0, 0, 9'h0, 0, 8'h0, 0);
    frame(4'h0, 4'h0, ID + 4'h1, 1, 4'h2, 0, 4'h6, 1, 9'h100, 0, 8'h0, 0);
    ack_count = 0;
    frame(4'h0, 4'h0, ID + 4'h1, 0, 4'h0, 0, 4'h0, 1, 9'h100, 0, 8'h0, 0);
    frame(4'h0, 4'h0, ID + 4'h1, 0, 4'h0, 0, 4'h0, 1, 9'h100, 0, 8'h0, 0);
    frame(4'h0, 4'h0, ID + 4'h1, 0, 4'h0, 0, 4'h0, 0, 9'h0, 0, 8'h0, 0);
    check("held_strobe_acks", ack_count, 3);

    // fill the whole ROM through the backdoor
    for (int i = 0; i < 256; i++)
      frame(4'h0, 4'h0, ID + 4'h1, 0, 4'h0, 0, 4'h0, 1, 9'(i), 1, 8'($urandom_range(0, 255)), 0);

    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 2);
      ra3 = (sel == 0) ? ID : (sel == 1) ? ID + 4'h1 : 4'($urandom_range(0, 15));
      sel = $urandom_range(0, 2);
      rm2 = (sel == 0) ? 4'h2 : (sel == 1) ? 4'hA : 4'($urandom_range(0, 15));
      frame(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), ra3,
            1'($urandom_range(0, 1)), rm2,
            1'($urandom_range(0, 1)), ($urandom_range(0, 1) != 0) ? ID : 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 255)), 0);
    end

    // reset inside M1 of a selected fetch, then refetch the same word
    frame(4'hC, 4'h3, ID, 0, 4'h0, 0, 4'h0, 0, 9'h0, 0, 8'h0, 1);
    frame(4'hC, 4'h3, ID, 0, 4'h0, 0, 4'h0, 0, 9'h0, 0, 8'h0, 0);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=%0d exp=%0d", total, 0);
    $fatal(1, "timeout");
  end
endmodule
